// File: rtl/axis_perf_counter_array_if.sv
// Tap bundle for the monitored AXI-Stream channels: handshake, last and keep
// only. The perf counter array observes it through the slave modport.
interface axis_perf_counter_array_if #(
    parameter int NUM_CH     = 2,
    parameter int KEEP_WIDTH = 64
);
    logic [NUM_CH-1:0]            mon_tvalid;
    logic [NUM_CH-1:0]            mon_tready;
    logic [NUM_CH-1:0]            mon_tlast;
    logic [NUM_CH*KEEP_WIDTH-1:0] mon_tkeep;

    modport master (output mon_tvalid, output mon_tready, output mon_tlast, output mon_tkeep);
    modport slave  (input  mon_tvalid, input  mon_tready, input  mon_tlast, input  mon_tkeep);
endinterface

// File: rtl/axis_perf_counter_array.sv
// Passive multi-channel AXI-Stream throughput monitor. Each channel measures a
// fixed window of WINDOW_CYCLES cycles, starting at the first handshake after
// arming, and accumulates saturating beat, byte and packet counts. A
// registered mux exposes one channel's counters for readout.
module axis_perf_counter_array #(
    parameter int          NUM_CH        = 2,
    parameter int          KEEP_WIDTH    = 64,
    parameter int          CNT_WIDTH     = 32,
    parameter int unsigned WINDOW_CYCLES = 250000000,
    parameter int          SEL_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int          BYTE_W        = CNT_WIDTH + $clog2(KEEP_WIDTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    axis_perf_counter_array_if.slave  mon,
    input  logic [NUM_CH-1:0]         enable,
    input  logic                      clear,
    output logic [NUM_CH-1:0]         done,
    input  logic [SEL_W-1:0]          rd_sel,
    output logic [1:0]                rd_state,
    output logic [CNT_WIDTH-1:0]      rd_cycle_cnt,
    output logic [CNT_WIDTH-1:0]      rd_beat_cnt,
    output logic [BYTE_W-1:0]         rd_byte_cnt,
    output logic [CNT_WIDTH-1:0]      rd_pkt_cnt,
    output logic                      rd_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int                   KW_W     = $clog2(KEEP_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] WIN_LAST = CNT_WIDTH'(WINDOW_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [BYTE_W-1:0]    BYTE_MAX = '1;

    state_t               state_q [NUM_CH];
    logic [CNT_WIDTH-1:0] cycle_q [NUM_CH];
    logic [CNT_WIDTH-1:0] beat_q  [NUM_CH];
    logic [CNT_WIDTH-1:0] pkt_q   [NUM_CH];
    logic [BYTE_W-1:0]    byte_q  [NUM_CH];
    logic [NUM_CH-1:0]    ovf_q;

    logic [NUM_CH-1:0]    hs;
    logic [KW_W-1:0]      pop      [NUM_CH];
    logic [CNT_WIDTH-1:0] beat_nxt [NUM_CH];
    logic [CNT_WIDTH-1:0] pkt_nxt  [NUM_CH];
    logic [BYTE_W-1:0]    byte_nxt [NUM_CH];
    logic [NUM_CH-1:0]    sat_nxt;
    logic [BYTE_W:0]      byte_sum;

    // Per-channel handshake, tkeep popcount and saturated next counter values.
    always_comb begin
        // NOTE: every combinational output is assigned before any conditional use, so no latch is inferred.
        byte_sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hs[i]  = mon.mon_tvalid[i] & mon.mon_tready[i];
            pop[i] = '0;
            for (int k = 0; k < KEEP_WIDTH; k++) begin
                pop[i] = pop[i] + KW_W'(mon.mon_tkeep[i*KEEP_WIDTH + k]);
            end
            beat_nxt[i] = (beat_q[i] == CNT_MAX) ? CNT_MAX : beat_q[i] + CNT_WIDTH'(1);
            pkt_nxt[i]  = (mon.mon_tlast[i] && pkt_q[i] != CNT_MAX) ? pkt_q[i] + CNT_WIDTH'(1)
                                                                    : pkt_q[i];
            byte_sum    = {1'b0, byte_q[i]} + (BYTE_W+1)'(pop[i]);
            byte_nxt[i] = byte_sum[BYTE_W] ? BYTE_MAX : byte_sum[BYTE_W-1:0];
            sat_nxt[i]  = (beat_nxt[i] == CNT_MAX) | (byte_nxt[i] == BYTE_MAX) |
                          (pkt_nxt[i] == CNT_MAX);
        end
    end

    // Per-channel window FSM and counters: reset > clear > enable-low > normal.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every channel sees pre-edge values.
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                cycle_q[i] <= '0;
                beat_q[i]  <= '0;
                byte_q[i]  <= '0;
                pkt_q[i]   <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clear) begin
                    state_q[i] <= ST_IDLE;
                    cycle_q[i] <= '0;
                    beat_q[i]  <= '0;
                    byte_q[i]  <= '0;
                    pkt_q[i]   <= '0;
                    ovf_q[i]   <= 1'b0;
                end else if (!enable[i]) begin
                    state_q[i] <= ST_IDLE;
                end else begin
                    unique case (state_q[i])
                        ST_IDLE: begin
                            state_q[i] <= ST_ARMED;
                            cycle_q[i] <= '0;
                            beat_q[i]  <= '0;
                            byte_q[i]  <= '0;
                            pkt_q[i]   <= '0;
                            ovf_q[i]   <= 1'b0;
                        end
                        // Counters are all zero while ARMED, so the first
                        // handshake is the same counting step as any RUN cycle.
                        ST_ARMED, ST_RUN: begin
                            if (state_q[i] == ST_RUN || hs[i]) begin
                                cycle_q[i] <= cycle_q[i] + CNT_WIDTH'(1);
                                state_q[i] <= (cycle_q[i] == WIN_LAST) ? ST_DONE : ST_RUN;
                            end
                            if (hs[i]) begin
                                beat_q[i] <= beat_nxt[i];
                                byte_q[i] <= byte_nxt[i];
                                pkt_q[i]  <= pkt_nxt[i];
                                ovf_q[i]  <= ovf_q[i] | sat_nxt[i];
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Done flags come straight from the state registers.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            done[i] = (state_q[i] == ST_DONE);
        end
    end

    // Registered readout mux; an out-of-range select reads as all zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state     <= '0;
            rd_cycle_cnt <= '0;
            rd_beat_cnt  <= '0;
            rd_byte_cnt  <= '0;
            rd_pkt_cnt   <= '0;
            rd_overflow  <= 1'b0;
        end else begin
            rd_state     <= '0;
            rd_cycle_cnt <= '0;
            rd_beat_cnt  <= '0;
            rd_byte_cnt  <= '0;
            rd_pkt_cnt   <= '0;
            rd_overflow  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (rd_sel == SEL_W'(i)) begin
                    rd_state     <= state_q[i];
                    rd_cycle_cnt <= cycle_q[i];
                    rd_beat_cnt  <= beat_q[i];
                    rd_byte_cnt  <= byte_q[i];
                    rd_pkt_cnt   <= pkt_q[i];
                    rd_overflow  <= ovf_q[i];
                end
            end
        end
    end

endmodule
